// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types, defaults and pair-index helper for the RO PUF controller
package puf_pkg;

    localparam int DEF_NUM_RO  = 16;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_WIN_CYC = 1024;
    localparam int DEF_RESP_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_COUNT,
        ST_COMPARE,
        ST_DONE
    } state_e;

    // num_ro is a power of two, so masking gives the natural index wrap
    function automatic logic [31:0] pair_idx(input logic [31:0] base,
                                             input logic [31:0] ofs,
                                             input int unsigned num_ro);
        return (base + ofs) & (num_ro - 1);
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - muxed rising-edge counter that saturates at all-ones
module ro_edge_counter #(
    parameter int NUM_RO = 16,
    parameter int CNT_W  = 16,
    parameter int SEL_W  = $clog2(NUM_RO)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_RO-1:0] rise_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && rise_i[sel_i] && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ro_puf_ctrl.sv
// rtl/ro_puf_ctrl.sv - ring-oscillator PUF controller: sync, pair race, response assembly
module ro_puf_ctrl
    import puf_pkg::*;
#(
    parameter int NUM_RO  = DEF_NUM_RO,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int WIN_CYC = DEF_WIN_CYC,
    parameter int RESP_W  = DEF_RESP_W,
    parameter int SEL_W   = $clog2(NUM_RO)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_RO-1:0] ro_in,
    input  logic              start,
    input  logic              abort,
    input  logic [SEL_W-1:0]  challenge,
    output logic              busy,
    output logic              done,
    output logic              resp_valid,
    output logic [RESP_W-1:0] response,
    output logic              sat
);

    localparam int BIT_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int WIN_W = $clog2(WIN_CYC + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(RESP_W - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);

    logic [NUM_RO-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_RO-1:0] rise;

    state_e            state_q;
    logic [SEL_W-1:0]  ch_q, a_sel_q, b_sel_q;
    logic [BIT_W-1:0]  bit_q;
    logic [WIN_W-1:0]  win_q;
    logic              busy_q, done_q, valid_q, sat_q;
    logic [RESP_W-1:0] resp_q;

    logic [SEL_W-1:0]  a_idx, b_idx;
    logic [CNT_W-1:0]  cnt_a, cnt_b;
    logic              sat_a, sat_b;
    logic              cnt_clr, cnt_en;

    // Oscillator inputs are asynchronous; the bank runs in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= ro_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise  = sync2_q & ~prev_q;
    assign a_idx = SEL_W'(pair_idx(32'(ch_q), 32'(bit_q), NUM_RO));
    assign b_idx = SEL_W'(pair_idx(32'(ch_q), 32'(bit_q) + 32'(NUM_RO / 2), NUM_RO));

    assign cnt_clr = (state_q == ST_SETUP);
    assign cnt_en  = (state_q == ST_COUNT);

    ro_edge_counter #(.NUM_RO(NUM_RO), .CNT_W(CNT_W), .SEL_W(SEL_W)) u_cnt_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .rise_i (rise),
        .sel_i  (a_sel_q),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (cnt_a),
        .sat_o  (sat_a)
    );

    ro_edge_counter #(.NUM_RO(NUM_RO), .CNT_W(CNT_W), .SEL_W(SEL_W)) u_cnt_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .rise_i (rise),
        .sel_i  (b_sel_q),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (cnt_b),
        .sat_o  (sat_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            a_sel_q <= '0;
            b_sel_q <= '0;
            bit_q   <= '0;
            win_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            resp_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            ch_q    <= challenge;
                            resp_q  <= '0;
                            valid_q <= 1'b0;
                            sat_q   <= 1'b0;
                            bit_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        a_sel_q <= a_idx;
                        b_sel_q <= b_idx;
                        win_q   <= '0;
                        state_q <= ST_COUNT;
                    end
                    ST_COUNT: begin
                        if (win_q == WIN_LAST) begin
                            state_q <= ST_COMPARE;
                        end else begin
                            win_q <= win_q + 1'b1;
                        end
                    end
                    ST_COMPARE: begin
                        // counts are final here, so saturation is folded in once per bit
                        resp_q[bit_q] <= (cnt_a > cnt_b);
                        sat_q         <= sat_q | sat_a | sat_b;
                        if (bit_q == BIT_LAST) begin
                            state_q <= ST_DONE;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            state_q <= ST_SETUP;
                        end
                    end
                    ST_DONE: begin
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign resp_valid = valid_q;
    assign response   = resp_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// tb/tb_ro_puf_ctrl.sv - scoreboard bench for ro_puf_ctrl with synchronous square-wave oscillators
module tb_ro_puf_ctrl;

    localparam int NRO = 16;
    localparam int WIN = 64;
    localparam int RW  = 8;
    localparam int LAT = RW * (WIN + 2) + 1;

    typedef struct packed {
        logic [RW-1:0] resp;
        logic          sat;
    } exp_t;

    logic           clk, rst_n;
    logic [NRO-1:0] ro_in;
    logic           start, abort, sel2;
    logic [3:0]     challenge;
    logic           busy1, done1, valid1, sat1;
    logic           busy2, done2, valid2, sat2;
    logic [RW-1:0]  resp1, resp2;
    logic           busy_m, done_m, valid_m, sat_m;
    logic [RW-1:0]  resp_m;

    int             per [NRO];
    int unsigned    tick;
    int             vectors, miscompares;
    exp_t           sb_q [$];

    ro_puf_ctrl #(.NUM_RO(NRO), .CNT_W(16), .WIN_CYC(WIN), .RESP_W(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ro_in      (ro_in),
        .start      (start & ~sel2),
        .abort      (abort & ~sel2),
        .challenge  (challenge),
        .busy       (busy1),
        .done       (done1),
        .resp_valid (valid1),
        .response   (resp1),
        .sat        (sat1)
    );

    ro_puf_ctrl #(.NUM_RO(NRO), .CNT_W(4), .WIN_CYC(WIN), .RESP_W(RW)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .ro_in      (ro_in),
        .start      (start & sel2),
        .abort      (abort & sel2),
        .challenge  (challenge),
        .busy       (busy2),
        .done       (done2),
        .resp_valid (valid2),
        .response   (resp2),
        .sat        (sat2)
    );

    assign busy_m  = sel2 ? busy2  : busy1;
    assign done_m  = sel2 ? done2  : done1;
    assign valid_m = sel2 ? valid2 : valid1;
    assign resp_m  = sel2 ? resp2  : resp1;
    assign sat_m   = sel2 ? sat2   : sat1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick  = 0;
        ro_in = '0;
        forever begin
            @(negedge clk);
            tick++;
            for (int i = 0; i < NRO; i++) begin
                ro_in[i] = (int'(tick % per[i]) < per[i] / 2);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_periods(input int fast_ro, input int fast_per);
        for (int i = 0; i < NRO; i++) per[i] = 8;
        if (fast_ro >= 0) per[fast_ro] = fast_per;
        repeat (10) @(posedge clk);
    endtask

    task automatic run(input logic use2, input logic [3:0] ch, input int restart_at,
                       input int abort_at, input logic [RW-1:0] exp_resp, input logic exp_sat);
        int   cyc, busy_gaps, spur;
        bit   got_done, aborted;
        exp_t e;
        sel2 = use2;
        @(negedge clk);
        challenge = ch;
        start     = 1'b1;
        if (abort_at < 0) sb_q.push_back({exp_resp, exp_sat});
        @(posedge clk); #1;
        check("busy_on_start", busy_m, 1'b1);
        check("valid_clr_on_start", valid_m, 1'b0);
        cyc = 0; busy_gaps = 0; got_done = 0; aborted = 0;
        while (!got_done && !aborted && cyc < LAT + 20) begin
            @(negedge clk);
            start = (cyc + 1 == restart_at);
            abort = (cyc + 1 == abort_at);
            @(posedge clk); #1;
            cyc++;
            if (cyc == abort_at) begin
                aborted = 1;
                abort   = 1'b0;
                check("abort_busy", busy_m, 1'b0);
                check("abort_valid", valid_m, 1'b0);
                spur = 0;
                repeat (LAT) begin
                    @(posedge clk); #1;
                    if (done_m) spur++;
                end
                check("abort_no_done", spur, 0);
            end else if (done_m) begin
                got_done = 1;
                check("latency", cyc, LAT);
                check("sb_nonempty", sb_q.size() > 0, 1'b1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("response", resp_m, e.resp);
                    check("sat", sat_m, e.sat);
                end
                check("valid_at_done", valid_m, 1'b1);
                check("busy_at_done", busy_m, 1'b0);
            end else if (!busy_m) begin
                busy_gaps++;
            end
        end
        if (!aborted) begin
            check("done_seen", got_done, 1'b1);
            check("busy_continuous", busy_gaps, 0);
            @(posedge clk); #1;
            check("done_one_cycle", done_m, 1'b0);
            check("valid_held", valid_m, 1'b1);
            check("response_held", resp_m, exp_resp);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel2 = 1'b0; challenge = '0;
        for (int i = 0; i < NRO; i++) per[i] = 8;
        #1;
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_valid", valid1, 1'b0);
        check("rst_response", resp1, 0);
        check("rst_sat", sat1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // start together with abort in IDLE must not be accepted
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        check("start_abort_ignored", busy1, 1'b0);
        @(negedge clk); start = 1'b0; abort = 1'b0;

        set_periods(3, 4);
        run(1'b0, 4'd3, -1, -1, 8'h01, 1'b0);

        set_periods(11, 4);
        run(1'b0, 4'd3, -1, -1, 8'h00, 1'b0);
        run(1'b0, 4'd11, -1, -1, 8'h01, 1'b0);

        set_periods(15, 4);
        run(1'b0, 4'd15, -1, -1, 8'h01, 1'b0);
        run(1'b0, 4'd15, 100, -1, 8'h01, 1'b0);
        run(1'b0, 4'd15, -1, 200, 8'h00, 1'b0);
        run(1'b0, 4'd15, -1, -1, 8'h01, 1'b0);

        set_periods(0, 2);
        run(1'b1, 4'd0, -1, -1, 8'h01, 1'b1);

        // mid-run asynchronous reset on the saturating instance
        sel2 = 1'b1;
        @(negedge clk); challenge = 4'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (300) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", busy2, 1'b0);
        check("arst_done", done2, 1'b0);
        check("arst_sat", sat2, 1'b0);
        check("arst_response", resp2, 0);
        check("arst_valid_other", valid1, 1'b0);
        check("arst_response_other", resp1, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
